// File: rtl/pcs_sync_fsm.sv
// pcs_sync_fsm -- 1000BASE-X style code-group synchronisation state machine.
//
// Watches the 10-bit code-group stream from the PMA and decides whether the
// receiver is aligned. Sync is declared after enough even-aligned commas. It is
// held while good code-groups outweigh bad ones, and lost on too many bad
// code-groups or when signal_detect drops.
//
// Ports
//   CLK            in   sole clock, rising edge
//   RESET          in   asynchronous, active-low reset
//   signal_detect  in   PMA signal present; 0 forces LOSS_OF_SYNC
//   cg_en          in   code-group strobe; qualifies rx_code_group/cg_invalid
//   rx_code_group  in   [9:0] received code-group (bit 9 = a ... bit 0 = j)
//   cg_invalid     in   decoder flag: not in 8b/10b table or disparity error
//   SYNC_STATUS    out  1 = synchronisation acquired
//   rx_even        out  alignment of the last accepted code-group (1 = even)
//   sync_state     out  [1:0] 00 LOSS, 01 COMMA_DETECT, 10 ACQUIRE, 11 SYNC
//   bad_cnt        out  [3:0] bad code-group count while in SYNC_ACQUIRED
//   rx_cg_out      out  [9:0] registered copy of rx_code_group
//   rx_cg_vld      out  registered copy of cg_en
module pcs_sync_fsm #(
  parameter int COMMAS_TO_SYNC  = 3,
  parameter int GOOD_TO_RECOVER = 4,
  parameter int BAD_TO_LOSS     = 4
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       signal_detect,
  input  logic       cg_en,
  input  logic [9:0] rx_code_group,
  input  logic       cg_invalid,
  output logic       SYNC_STATUS,
  output logic       rx_even,
  output logic [1:0] sync_state,
  output logic [3:0] bad_cnt,
  output logic [9:0] rx_cg_out,
  output logic       rx_cg_vld
);

  localparam logic [1:0] ST_LOSS_OF_SYNC  = 2'b00;
  localparam logic [1:0] ST_COMMA_DETECT  = 2'b01;
  localparam logic [1:0] ST_ACQUIRE_SYNC  = 2'b10;
  localparam logic [1:0] ST_SYNC_ACQUIRED = 2'b11;

  // Thresholds widened by one bit so "count + 1" comparisons cannot wrap.
  localparam logic [4:0] L_COMMAS = 5'(COMMAS_TO_SYNC);
  localparam logic [4:0] L_GOOD   = 5'(GOOD_TO_RECOVER);
  localparam logic [4:0] L_BAD    = 5'(BAD_TO_LOSS);

  logic [1:0] r_state;
  logic [3:0] r_comma_cnt;
  logic [3:0] r_bad_cnt;
  logic [3:0] r_good_cnt;
  logic       r_rx_even;
  logic       r_sync_status;
  logic [9:0] r_rx_cg;
  logic       r_rx_vld;

  logic [1:0] w_state_next;
  logic [3:0] w_comma_next;
  logic [3:0] w_bad_next;
  logic [3:0] w_good_next;
  logic       w_even_next;
  logic       w_comma;
  logic       w_cgbad;

  assign w_comma = (rx_code_group[9:3] == 7'b0011111) ||
                   (rx_code_group[9:3] == 7'b1100000);
  // Registered rx_even == 1 means the incoming code-group sits at an odd slot.
  assign w_cgbad = cg_invalid || (w_comma && r_rx_even);

  always_comb begin
    w_state_next = r_state;
    w_comma_next = r_comma_cnt;
    w_bad_next   = r_bad_cnt;
    w_good_next  = r_good_cnt;
    w_even_next  = r_rx_even;

    if (!signal_detect) begin
      w_state_next = ST_LOSS_OF_SYNC;
      w_comma_next = 4'd0;
      w_bad_next   = 4'd0;
      w_good_next  = 4'd0;
      if (cg_en) begin
        w_even_next = ~r_rx_even;
      end
    end else if (cg_en) begin
      w_even_next = ~r_rx_even;
      case (r_state)
        ST_LOSS_OF_SYNC: begin
          if (w_comma && !cg_invalid) begin
            w_state_next = ST_COMMA_DETECT;
            w_even_next  = 1'b1;
            w_comma_next = 4'd1;
          end
        end
        ST_COMMA_DETECT: begin
          if (!w_comma && !cg_invalid) begin
            if ({1'b0, r_comma_cnt} == L_COMMAS) begin
              w_state_next = ST_SYNC_ACQUIRED;
              w_bad_next   = 4'd0;
              w_good_next  = 4'd0;
            end else begin
              w_state_next = ST_ACQUIRE_SYNC;
            end
          end else begin
            w_state_next = ST_LOSS_OF_SYNC;
            w_comma_next = 4'd0;
            w_bad_next   = 4'd0;
            w_good_next  = 4'd0;
          end
        end
        ST_ACQUIRE_SYNC: begin
          if (w_cgbad) begin
            w_state_next = ST_LOSS_OF_SYNC;
            w_comma_next = 4'd0;
            w_bad_next   = 4'd0;
            w_good_next  = 4'd0;
          end else if (w_comma) begin
            // Not cgbad, so this comma is valid and even-aligned.
            w_state_next = ST_COMMA_DETECT;
            w_even_next  = 1'b1;
            if (r_comma_cnt != 4'd15) begin
              w_comma_next = r_comma_cnt + 4'd1;
            end
          end
        end
        default: begin // ST_SYNC_ACQUIRED
          if (w_cgbad) begin
            w_good_next = 4'd0;
            if (({1'b0, r_bad_cnt} + 5'd1) == L_BAD) begin
              w_state_next = ST_LOSS_OF_SYNC;
              w_comma_next = 4'd0;
              w_bad_next   = 4'd0;
            end else begin
              w_bad_next = r_bad_cnt + 4'd1;
            end
          end else if (r_bad_cnt != 4'd0) begin
            if (({1'b0, r_good_cnt} + 5'd1) == L_GOOD) begin
              w_bad_next  = r_bad_cnt - 4'd1;
              w_good_next = 4'd0;
            end else begin
              w_good_next = r_good_cnt + 4'd1;
            end
          end else begin
            w_good_next = 4'd0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state       <= ST_LOSS_OF_SYNC;
      r_comma_cnt   <= 4'd0;
      r_bad_cnt     <= 4'd0;
      r_good_cnt    <= 4'd0;
      r_rx_even     <= 1'b0;
      r_sync_status <= 1'b0;
      r_rx_cg       <= 10'd0;
      r_rx_vld      <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_comma_cnt   <= w_comma_next;
      r_bad_cnt     <= w_bad_next;
      r_good_cnt    <= w_good_next;
      r_rx_even     <= w_even_next;
      // Derived from the next state so status follows the transition edge.
      r_sync_status <= (w_state_next == ST_SYNC_ACQUIRED);
      r_rx_cg       <= rx_code_group;
      r_rx_vld      <= cg_en;
    end
  end

  assign SYNC_STATUS = r_sync_status;
  assign rx_even     = r_rx_even;
  assign sync_state  = r_state;
  assign bad_cnt     = r_bad_cnt;
  assign rx_cg_out   = r_rx_cg;
  assign rx_cg_vld   = r_rx_vld;

endmodule

// File: tb/tb_pcs_sync_fsm.sv
// Directed self-checking bench for pcs_sync_fsm (default parameters).
module tb_pcs_sync_fsm;

  logic       CLK;
  logic       RESET;
  logic       signal_detect;
  logic       cg_en;
  logic [9:0] rx_code_group;
  logic       cg_invalid;
  logic       SYNC_STATUS;
  logic       rx_even;
  logic [1:0] sync_state;
  logic [3:0] bad_cnt;
  logic [9:0] rx_cg_out;
  logic       rx_cg_vld;

  int n_tests;
  int n_fail;

  localparam logic [9:0] K285 = 10'b0011111010;
  localparam logic [9:0] D162 = 10'b0110110101;

  pcs_sync_fsm dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .signal_detect (signal_detect),
    .cg_en         (cg_en),
    .rx_code_group (rx_code_group),
    .cg_invalid    (cg_invalid),
    .SYNC_STATUS   (SYNC_STATUS),
    .rx_even       (rx_even),
    .sync_state    (sync_state),
    .bad_cnt       (bad_cnt),
    .rx_cg_out     (rx_cg_out),
    .rx_cg_vld     (rx_cg_vld)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the edge.
  task automatic send(input logic [9:0] cg, input logic inv, input logic en);
    rx_code_group = cg;
    cg_invalid    = inv;
    cg_en         = en;
    @(posedge CLK);
    #1;
  endtask

  // Six-group acquisition stream: K28.5/D16.2 x3 -> 01,10,01,10,01,11.
  task automatic acquire(input string tag, input int gap_mode);
    logic [1:0] exp_st [6];
    logic [1:0] held;
    int gap;
    exp_st = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b11};
    for (int i = 0; i < 6; i++) begin
      if (gap_mode != 0) begin
        gap  = (i % 5) + 1;
        held = sync_state;
        for (int g = 0; g < gap; g++) begin
          send(K285, 1'b0, 1'b0);
          chk({tag, "_gap_state"}, {8'd0, sync_state}, {8'd0, held});
          chk({tag, "_gap_vld"}, {9'd0, rx_cg_vld}, 10'd0);
        end
      end
      send((i % 2 == 0) ? K285 : D162, 1'b0, 1'b1);
      $display("[TB] %s cg%0d state=%b sync=%b even=%b", tag, i, sync_state, SYNC_STATUS, rx_even);
      chk({tag, "_state"}, {8'd0, sync_state}, {8'd0, exp_st[i]});
      chk({tag, "_sync"}, {9'd0, SYNC_STATUS}, {9'd0, (i == 5)});
      chk({tag, "_vld"}, {9'd0, rx_cg_vld}, 10'd1);
    end
  endtask

  initial begin
    n_tests       = 0;
    n_fail        = 0;
    RESET         = 1'b1;
    signal_detect = 1'b1;
    cg_en         = 1'b0;
    rx_code_group = 10'd0;
    cg_invalid    = 1'b0;

    // Reset values, applied asynchronously before any clock edge.
    #1 RESET = 1'b0;
    #1;
    chk("rst_state", {8'd0, sync_state}, 10'd0);
    chk("rst_sync", {9'd0, SYNC_STATUS}, 10'd0);
    chk("rst_even", {9'd0, rx_even}, 10'd0);
    chk("rst_bad", {6'd0, bad_cnt}, 10'd0);
    chk("rst_cg", rx_cg_out, 10'd0);
    chk("rst_vld", {9'd0, rx_cg_vld}, 10'd0);
    #5 RESET = 1'b1;

    // Basic acquisition.
    acquire("acq1", 0);
    chk("acq1_cgout", rx_cg_out, D162);
    chk("acq1_even", {9'd0, rx_even}, 10'd0);

    // Bad-count accounting: 3 bad, 4 good, 2 bad.
    for (int i = 0; i < 3; i++) send(D162, 1'b1, 1'b1);
    $display("[TB] bad3 bad_cnt=%0d sync=%b", bad_cnt, SYNC_STATUS);
    chk("bad3_cnt", {6'd0, bad_cnt}, 10'd3);
    chk("bad3_sync", {9'd0, SYNC_STATUS}, 10'd1);
    for (int i = 0; i < 3; i++) begin
      send(D162, 1'b0, 1'b1);
      chk("good_hold_cnt", {6'd0, bad_cnt}, 10'd3);
    end
    send(D162, 1'b0, 1'b1);
    $display("[TB] good4 bad_cnt=%0d", bad_cnt);
    chk("good4_cnt", {6'd0, bad_cnt}, 10'd2);
    send(D162, 1'b1, 1'b1);
    chk("bad_again_cnt", {6'd0, bad_cnt}, 10'd3);
    chk("bad_again_state", {8'd0, sync_state}, 10'd3);
    send(D162, 1'b1, 1'b1);
    $display("[TB] loss state=%b sync=%b bad=%0d", sync_state, SYNC_STATUS, bad_cnt);
    chk("loss_state", {8'd0, sync_state}, 10'd0);
    chk("loss_sync", {9'd0, SYNC_STATUS}, 10'd0);
    chk("loss_bad", {6'd0, bad_cnt}, 10'd0);

    // Odd-position comma during ACQUIRE_SYNC.
    send(K285, 1'b0, 1'b1);
    chk("odd_cd_state", {8'd0, sync_state}, 10'd1);
    chk("odd_cd_even", {9'd0, rx_even}, 10'd1);
    send(D162, 1'b0, 1'b1);
    chk("odd_acq_state", {8'd0, sync_state}, 10'd2);
    send(D162, 1'b0, 1'b1);
    chk("odd_acq_hold", {8'd0, sync_state}, 10'd2);
    chk("odd_acq_even", {9'd0, rx_even}, 10'd1);
    send(K285, 1'b0, 1'b1);
    $display("[TB] odd comma state=%b sync=%b", sync_state, SYNC_STATUS);
    chk("odd_comma_state", {8'd0, sync_state}, 10'd0);
    chk("odd_comma_sync", {9'd0, SYNC_STATUS}, 10'd0);

    // signal_detect drop in sync with cg_en low.
    acquire("acq2", 0);
    send(D162, 1'b1, 1'b1);
    chk("sd_pre_bad", {6'd0, bad_cnt}, 10'd1);
    signal_detect = 1'b0;
    send(D162, 1'b0, 1'b0);
    signal_detect = 1'b1;
    $display("[TB] sigdet drop state=%b bad=%0d sync=%b", sync_state, bad_cnt, SYNC_STATUS);
    chk("sd_state", {8'd0, sync_state}, 10'd0);
    chk("sd_bad", {6'd0, bad_cnt}, 10'd0);
    chk("sd_sync", {9'd0, SYNC_STATUS}, 10'd0);

    // Acquisition with cg_en gaps of 1..5 cycles.
    acquire("gap", 1);

    // Asynchronous reset mid-SYNC_ACQUIRED.
    send(D162, 1'b1, 1'b1);
    chk("arst_pre_bad", {6'd0, bad_cnt}, 10'd1);
    #2 RESET = 1'b0;
    #1;
    $display("[TB] async reset state=%b sync=%b bad=%0d vld=%b", sync_state, SYNC_STATUS, bad_cnt, rx_cg_vld);
    chk("arst_state", {8'd0, sync_state}, 10'd0);
    chk("arst_sync", {9'd0, SYNC_STATUS}, 10'd0);
    chk("arst_even", {9'd0, rx_even}, 10'd0);
    chk("arst_bad", {6'd0, bad_cnt}, 10'd0);
    chk("arst_cg", rx_cg_out, 10'd0);
    chk("arst_vld", {9'd0, rx_cg_vld}, 10'd0);
    #2 RESET = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
